// File: rtl/mcu_pkg.sv
// mcu_pkg: shared states, opcodes, status-register bit indices and field widths
// for the mcu_core_p accumulator core.
package mcu_pkg;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int SR_Z = 0;
    localparam int SR_C = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 3;

    localparam int OPC_W = 4;
    localparam int SR_W  = 4;

endpackage

// File: rtl/mcu_alu_p.sv
// mcu_alu_p: combinational ALU producing the new accumulator value and status flags;
// ops that do not touch the accumulator pass Acc and SR through unchanged.
module mcu_alu_p
    import mcu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OPC_W-1:0]  i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_opnd,
    input  logic [SR_W-1:0]   i_sr,
    output logic [DATA_W-1:0] o_res,
    output logic [SR_W-1:0]   o_sr
);

    localparam int M = DATA_W - 1;

    logic [DATA_W:0]   w_add;
    logic [DATA_W-1:0] w_sub;
    logic              w_upd;

    assign w_add = {1'b0, i_acc} + {1'b0, i_opnd};
    assign w_sub = i_acc - i_opnd;

    always_comb begin
        o_res = i_acc;
        o_sr  = i_sr;
        w_upd = 1'b0;
        case (i_op)
            OP_LDI, OP_LD: begin
                o_res = i_opnd;
                w_upd = 1'b1;
            end
            OP_ADDI, OP_ADD: begin
                o_res       = w_add[M:0];
                w_upd       = 1'b1;
                o_sr[SR_C]  = w_add[DATA_W];
                o_sr[SR_V]  = (i_acc[M] == i_opnd[M]) && (w_add[M] != i_acc[M]);
            end
            OP_SUBI, OP_SUB: begin
                o_res       = w_sub;
                w_upd       = 1'b1;
                o_sr[SR_C]  = i_acc < i_opnd;
                o_sr[SR_V]  = (i_acc[M] != i_opnd[M]) && (w_sub[M] != i_acc[M]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                o_res       = (i_op == OP_AND) ? (i_acc & i_opnd) :
                              (i_op == OP_OR)  ? (i_acc | i_opnd) : (i_acc ^ i_opnd);
                w_upd       = 1'b1;
                o_sr[SR_C]  = 1'b0;
                o_sr[SR_V]  = 1'b0;
            end
            default: ;
        endcase
        if (w_upd) begin
            o_sr[SR_Z] = (o_res == '0);
            o_sr[SR_N] = o_res[M];
        end
    end

endmodule

// File: rtl/mcu_core_p.sv
// mcu_core_p: accumulator MCU with streamed program load, LOAD/FETCH/DECODE/EXECUTE/HALT
// sequencing and a back-pressured output port. MCU_RETIRE_CNT_EN enables retire_count.
module mcu_core_p
    import mcu_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  PMEM_DEPTH = 256,
    parameter int  DMEM_DEPTH = 16,
    localparam int PC_W       = $clog2(PMEM_DEPTH),
    localparam int DA_W       = $clog2(DMEM_DEPTH),
    localparam int INSTR_W    = OPC_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               halted,
    output logic [2:0]         state,
    output logic [31:0]        retire_count
);

    localparam logic [PC_W-1:0] PC_MAX = PC_W'(PMEM_DEPTH - 1);

    state_t              r_state, w_next;
    logic [PC_W-1:0]     r_pc, r_ld_addr, w_pc_inc, w_pc_nxt;
    logic [DATA_W-1:0]   r_acc, r_dr, r_out, w_res, w_opnd;
    logic [SR_W-1:0]     r_sr, w_sr;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_load_rdy, r_out_vld;
    logic [OPC_W-1:0]    w_op;
    logic [DATA_W-1:0]   w_imm;
    logic                w_beat, w_load_done, w_stall, w_take, w_exec_go;

    logic [INSTR_W-1:0]  r_pmem [PMEM_DEPTH];
    logic [DATA_W-1:0]   r_dmem [DMEM_DEPTH];

    assign w_op        = r_ir[INSTR_W-1:DATA_W];
    assign w_imm       = r_ir[DATA_W-1:0];
    assign w_beat      = load_valid && r_load_rdy;
    assign w_load_done = w_beat && (load_last || r_ld_addr == PC_MAX);
    // A new OUT may proceed in the same cycle the pending word is popped.
    assign w_stall     = (w_op == OP_OUT) && r_out_vld && !out_ready;
    assign w_exec_go   = (r_state == ST_EXEC) && !w_stall;
    assign w_pc_inc    = (r_pc == PC_MAX) ? '0 : r_pc + 1'b1;
    assign w_take      = (w_op == OP_JMP) || (w_op == OP_JZ && r_sr[SR_Z]) || (w_op == OP_JC && r_sr[SR_C]);
    assign w_pc_nxt    = (w_op == OP_HLT) ? r_pc : w_take ? w_imm[PC_W-1:0] : w_pc_inc;
    assign w_opnd      = (w_op == OP_LDI || w_op == OP_ADDI || w_op == OP_SUBI) ? w_imm : r_dr;

    mcu_alu_p #(.DATA_W(DATA_W)) u_alu (
        .i_op   (w_op),
        .i_acc  (r_acc),
        .i_opnd (w_opnd),
        .i_sr   (r_sr),
        .o_res  (w_res),
        .o_sr   (w_sr)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD:   w_next = w_load_done ? ST_FETCH : ST_LOAD;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = (w_op == OP_HLT) ? ST_HALT : w_stall ? ST_EXEC : ST_FETCH;
            default:   w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_rdy <= 1'b0;
            r_ld_addr  <= '0;
            r_pc       <= '0;
            r_acc      <= '0;
            r_sr       <= '0;
            r_ir       <= '0;
            r_dr       <= '0;
            r_out_vld  <= 1'b0;
            r_out      <= '0;
        end else begin
            r_load_rdy <= (w_next == ST_LOAD);
            if (w_beat) r_ld_addr <= w_load_done ? '0 : r_ld_addr + 1'b1;
            if (w_load_done) begin
                r_pc  <= '0;
                r_acc <= '0;
                r_sr  <= '0;
                r_ir  <= '0;
            end
            if (r_state == ST_FETCH) r_ir <= r_pmem[r_pc];
            if (r_state == ST_DECODE) r_dr <= r_dmem[w_imm[DA_W-1:0]];
            if (w_exec_go) begin
                r_acc <= w_res;
                r_sr  <= w_sr;
                r_pc  <= w_pc_nxt;
            end
            if (w_exec_go && w_op == OP_OUT) begin
                r_out_vld <= 1'b1;
                r_out     <= r_acc;
            end else if (out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_beat) r_pmem[r_ld_addr] <= load_data;
        if (!rst && w_exec_go && w_op == OP_ST) r_dmem[w_imm[DA_W-1:0]] <= r_acc;
    end

`ifdef MCU_RETIRE_CNT_EN
    logic [31:0] r_retire;
    always_ff @(posedge clk) begin
        if (rst || w_load_done)         r_retire <= '0;
        else if (w_exec_go && r_retire != '1) r_retire <= r_retire + 1'b1;
    end
    assign retire_count = r_retire;
`else
    assign retire_count = '0;
`endif

    assign load_ready = r_load_rdy;
    assign out_valid  = r_out_vld;
    assign out_data   = r_out;
    assign halted     = (r_state == ST_HALT);
    assign state      = r_state;

endmodule

// File: tb/tb_mcu_core_p.sv
// tb_mcu_core_p: directed and randomized program runs against an instruction-level model.
module tb_mcu_core_p;

    logic        clk = 1'b0, rst = 1'b1;
    logic        load_valid = 1'b0, load_last = 1'b0, out_ready = 1'b0;
    logic [11:0] load_data = '0;
    logic        load_ready, out_valid, halted;
    logic [7:0]  out_data;
    logic [2:0]  state;
    logic [31:0] retire_count;

    int          checks = 0, errors = 0;
    logic [11:0] prog [256];
    int          plen;
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    int          m_pc, m_ret;
    logic [3:0]  m_sr;

    always #5 clk = ~clk;

    mcu_core_p dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .halted       (halted),
        .state        (state),
        .retire_count (retire_count)
    );

    always @(posedge clk) if (!rst && out_valid && out_ready) got.push_back(out_data);

    function automatic logic [11:0] enc(input logic [3:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 8'hxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_retire(input string tag, input int n);
`ifdef MCU_RETIRE_CNT_EN
        chk(tag, retire_count, n);
`else
        chk(tag, retire_count, 0);
`endif
    endtask

    // Instruction-level interpreter: sequential PC, flag rules as signed/unsigned arithmetic.
    task automatic model();
        int  pc = 0, acc = 0, b = 0, r = 0, s = 0, imm = 0, steps = 0;
        int  dm [16];
        bit  z = 0, c = 0, n = 0, v = 0, done = 0, jmp = 0;
        logic [3:0] op;
        exp_q.delete();
        foreach (dm[i]) dm[i] = 0;
        while (!done && steps < 5000) begin
            op    = prog[pc][11:8];
            imm   = int'(prog[pc][7:0]);
            jmp   = 0;
            steps++;
            b     = (op == 4'h4 || op == 4'h6 || op == 4'h1) ? imm : dm[imm % 16];
            if (op == 4'h1 || op == 4'h2) begin
                acc = b;
                z = (acc == 0); n = (acc >= 128);
            end else if (op == 4'h3) begin
                dm[imm % 16] = acc;
            end else if (op == 4'h4 || op == 4'h5) begin
                r = acc + b; s = sgn(acc) + sgn(b);
                c = (r > 255); v = (s > 127 || s < -128);
                acc = r & 255; z = (acc == 0); n = (acc >= 128);
            end else if (op == 4'h6 || op == 4'h7) begin
                r = acc - b; s = sgn(acc) - sgn(b);
                c = (acc < b); v = (s > 127 || s < -128);
                acc = r & 255; z = (acc == 0); n = (acc >= 128);
            end else if (op >= 4'h8 && op <= 4'hA) begin
                acc = (op == 4'h8) ? (acc & b) : (op == 4'h9) ? (acc | b) : (acc ^ b);
                c = 0; v = 0; z = (acc == 0); n = (acc >= 128);
            end else if (op == 4'hB) begin
                jmp = 1;
            end else if (op == 4'hC) begin
                jmp = z;
            end else if (op == 4'hD) begin
                jmp = c;
            end else if (op == 4'hE) begin
                exp_q.push_back(8'(acc));
            end else if (op == 4'hF) begin
                done = 1;
            end
            if (!done) pc = jmp ? imm : (pc + 1) % 256;
        end
        m_pc  = pc;
        m_sr  = {v, n, c, z};
        m_ret = steps;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
    endtask

    task automatic load(input int n, input bit last);
        int t = 0;
        while (!load_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("load_ready_up", load_ready, 1);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = last && (i == n - 1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int n, input bit last);
        int t = 0;
        do_reset();
        load(n, last);
        chk({tag, "_fetch"}, state, 1);
        chk({tag, "_ready_low"}, load_ready, 0);
        model();
        while (!halted && t < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        chk({tag, "_halted"}, halted, 1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_nout"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk({tag, "_out"}, got_at(i), exp_q[i]);
        chk({tag, "_pc"}, dut.r_pc, m_pc);
        chk({tag, "_sr"}, dut.r_sr, m_sr);
        chk({tag, "_state"}, state, 4);
        chk_retire({tag, "_retire"}, m_ret);
    endtask

    task automatic gen_rand();
        int idx = 0;
        logic [3:0] op;
        for (int a = 0; a < 16; a++) begin
            prog[idx] = enc(4'h1, 8'($urandom)); idx++;
            prog[idx] = enc(4'h3, 8'(a));        idx++;
        end
        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(0, 14));
            prog[idx] = (op >= 4'hB && op <= 4'hD) ? enc(op, 8'(idx + 2)) : enc(op, 8'($urandom));
            idx++;
        end
        prog[idx]     = enc(4'hE, 8'h00);
        prog[idx + 1] = enc(4'hF, 8'h00);
        plen = idx + 2;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire_count, 0);
        rst = 1'b0;

        // Basic program and latency from FETCH entry
        prog[0] = enc(4'h1, 8'd5); prog[1] = enc(4'h4, 8'd3);
        prog[2] = enc(4'hE, 8'd0); prog[3] = enc(4'hF, 8'd0);
        do_reset();
        load(4, 1);
        chk("basic_fetch", state, 1);
        chk("basic_ready_low", load_ready, 0);
        repeat (11) @(negedge clk);
        chk("basic_not_yet_halted", halted, 0);
        @(negedge clk);
        chk("basic_halted", halted, 1);
        chk("basic_state", state, 4);
        chk("basic_out_valid", out_valid, 1);
        chk("basic_out_data", out_data, 8);
        chk_retire("basic_retire", 4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("basic_popped", out_valid, 0);
        chk("basic_got", got_at(0), 8'h08);

        // Flags on add wrap and signed overflow
        prog[0] = enc(4'h1, 8'hFF); prog[1] = enc(4'h4, 8'h01);
        prog[2] = enc(4'hE, 8'h00); prog[3] = enc(4'hF, 8'h00);
        run_prog("add_wrap", 4, 1);
        chk("add_wrap_val", got_at(0), 8'h00);
        chk("add_wrap_flags", dut.r_sr, 4'b0011);
        prog[0] = enc(4'h1, 8'h7F);
        run_prog("add_ovf", 4, 1);
        chk("add_ovf_val", got_at(0), 8'h80);
        chk("add_ovf_flags", dut.r_sr, 4'b1100);

        // Borrow-driven JC taken / not taken
        for (int i = 0; i < 18; i++) prog[i] = enc(4'h0, 8'h00);
        prog[0]  = enc(4'h1, 8'd3); prog[1] = enc(4'h6, 8'd5); prog[2] = enc(4'hD, 8'h10);
        prog[3]  = enc(4'hE, 8'h00); prog[4] = enc(4'hF, 8'h00);
        prog[16] = enc(4'hE, 8'h00); prog[17] = enc(4'hF, 8'h00);
        run_prog("jc_taken", 18, 1);
        chk("jc_taken_val", got_at(0), 8'hFE);
        chk("jc_taken_pc", dut.r_pc, 8'h11);
        prog[0] = enc(4'h1, 8'd5);
        run_prog("jc_not", 18, 1);
        chk("jc_not_val", got_at(0), 8'h00);
        chk("jc_not_pc", dut.r_pc, 8'h04);

        // Back-to-back OUT under back-pressure
        prog[0] = enc(4'h1, 8'hA1); prog[1] = enc(4'hE, 8'h00);
        prog[2] = enc(4'h1, 8'hB2); prog[3] = enc(4'hE, 8'h00); prog[4] = enc(4'hF, 8'h00);
        do_reset();
        load(5, 1);
        repeat (15) @(negedge clk);
        chk("stall_pc_a", dut.r_pc, 3);
        repeat (5) @(negedge clk);
        chk("stall_state", state, 3);
        chk("stall_pc_b", dut.r_pc, 3);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 8'hA1);
        chk("stall_none_popped", got.size(), 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_pop1", got_at(0), 8'hA1);
        chk("stall_reload_valid", out_valid, 1);
        chk("stall_reload_data", out_data, 8'hB2);
        @(negedge clk);
        chk("stall_pop2", got_at(1), 8'hB2);
        chk("stall_count", got.size(), 2);
        out_ready = 1'b0;

        // Full 256-word load without load_last; JMP 0xFF then wrap to 0
        for (int i = 0; i < 256; i++) prog[i] = enc(4'h0, 8'h00);
        prog[0] = enc(4'hC, 8'h03); prog[1] = enc(4'h1, 8'h00); prog[2] = enc(4'hB, 8'hFF);
        prog[3] = enc(4'h1, 8'h77); prog[4] = enc(4'hE, 8'h00); prog[5] = enc(4'hF, 8'h00);
        run_prog("full_wrap", 256, 0);
        chk("full_wrap_val", got_at(0), 8'h77);
        chk("full_wrap_pc", dut.r_pc, 5);

        // Reset mid-load, then reload from address 0
        prog[0] = enc(4'hF, 8'h00); prog[1] = enc(4'hF, 8'h00);
        do_reset();
        load(2, 0);
        load_valid = 1'b1; load_data = enc(4'hF, 8'h00); rst = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("mid_load_state", state, 0);
        chk("mid_load_ready", load_ready, 0);
        chk("mid_load_out_valid", out_valid, 0);
        chk("mid_load_retire", retire_count, 0);
        rst = 1'b0;
        prog[0] = enc(4'h1, 8'd5); prog[1] = enc(4'h4, 8'd3);
        prog[2] = enc(4'hE, 8'd0); prog[3] = enc(4'hF, 8'd0);
        load(4, 1);
        repeat (12) @(negedge clk);
        chk("reload_halted", halted, 1);
        chk("reload_data", out_data, 8'h08);

        // Reset during a stalled OUT
        prog[0] = enc(4'h1, 8'h11); prog[1] = enc(4'hE, 8'h00);
        prog[2] = enc(4'hE, 8'h00); prog[3] = enc(4'hF, 8'h00);
        do_reset();
        load(4, 1);
        repeat (15) @(negedge clk);
        chk("stall2_state", state, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("stall2_rst_state", state, 0);
        chk("stall2_rst_valid", out_valid, 0);
        chk("stall2_rst_data", out_data, 0);
        chk("stall2_rst_halted", halted, 0);
        chk("stall2_rst_retire", retire_count, 0);
        rst = 1'b0;

        // Randomized programs against the model
        for (int r = 0; r < 8; r++) begin
            gen_rand();
            run_prog("rnd", plen, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
